// File: rtl/instruction_queue_if.sv
// instruction_queue_if: ctl_word type and the IR-to-queue handshake interface
package tomasula_types;
    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } ctl_word;
endpackage

interface IQ_2_IR;
    import tomasula_types::*;
    ctl_word control_word;
    logic    ld_iq;
    logic    ack_o;
    modport IQ_SIG(input control_word, input ld_iq, output ack_o);
    modport IR_SIG(output control_word, output ld_iq, input ack_o);
endinterface

// File: rtl/instruction_queue.sv
// instruction_queue: in-order ctl_word FIFO from IR to dispatch; define IQ_BYPASS_EN for empty-queue bypass
module instruction_queue
    import tomasula_types::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    IQ_2_IR.IQ_SIG                   iq_ir_itf,
    input  logic                     flush_i,
    input  logic                     deq_i,
    output logic                     valid_o,
    output ctl_word                  ctl_out,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int PW = $clog2(DEPTH);

    ctl_word         mem_q [DEPTH];
    ctl_word         mem_d [DEPTH];
    logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [PW:0]     count_q, count_d;
    logic            byp, pass, wr, pop;

    always_comb begin
        full_o = count_q == (PW+1)'(DEPTH);
        iq_ir_itf.ack_o = iq_ir_itf.ld_iq & ~full_o & ~flush_i & ~rst;
`ifdef IQ_BYPASS_EN
        byp = (count_q == '0) & iq_ir_itf.ld_iq & ~flush_i & ~rst;
`else
        byp = 1'b0;
`endif
        valid_o = (count_q != '0) | byp;
        ctl_out = byp ? iq_ir_itf.control_word : mem_q[head_q];
        // a bypassed word consumed this cycle never touches storage or count
        pass = byp & deq_i;
        wr = iq_ir_itf.ack_o & ~pass;
        pop = deq_i & valid_o & ~pass;
        mem_d = mem_q;
        if (wr) mem_d[tail_q] = iq_ir_itf.control_word;
        head_d = flush_i ? '0 : head_q + PW'(pop);
        tail_d = flush_i ? '0 : tail_q + PW'(wr);
        count_d = flush_i ? '0 : count_q + (PW+1)'(wr) - (PW+1)'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            count_q <= '0;
            mem_q <= '{default: '0};
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            count_q <= count_d;
            mem_q <= mem_d;
        end
    end

    assign count_o = count_q;
endmodule

// File: tb/tb_instruction_queue.sv
// tb_instruction_queue: scoreboard bench for instruction_queue (DEPTH=8), with or without IQ_BYPASS_EN
module tb_instruction_queue;
    import tomasula_types::*;
    localparam bit BYP =
`ifdef IQ_BYPASS_EN
        1'b1;
`else
        1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, flush_i, deq_i;
    logic       valid_o, full_o;
    ctl_word    ctl_out;
    logic [3:0] count_o;
    int         vecs = 0, errs = 0;
    ctl_word    sb[$];

    IQ_2_IR itf();

    instruction_queue #(.DEPTH(8)) dut (
        .clk(clk), .rst(rst), .iq_ir_itf(itf), .flush_i(flush_i), .deq_i(deq_i),
        .valid_o(valid_o), .ctl_out(ctl_out), .full_o(full_o), .count_o(count_o)
    );

    always #5 clk = ~clk;

    function automatic ctl_word mk(input logic [31:0] pc);
        ctl_word w;
        w.pc = pc;
        w.op = pc[5:2];
        w.rd = pc[6:2];
        w.rs1 = pc[4:0] ^ 5'h1f;
        w.rs2 = pc[8:4];
        w.imm = ~pc;
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic ld, input logic [31:0] pc, input logic dq, input logic fl);
        itf.ld_iq = ld;
        itf.control_word = mk(pc);
        deq_i = dq;
        flush_i = fl;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_in(1'b1, 32'h60, 1'b0, 1'b0);
        tick();
        tick();
        vecs++; if (itf.ack_o !== 1'b0) begin errs++; $display("FAIL reset_ack: got %b want 0", itf.ack_o); end
        vecs++; if (valid_o !== 1'b0) begin errs++; $display("FAIL reset_valid: got %b want 0", valid_o); end
        vecs++; if (count_o !== 4'd0) begin errs++; $display("FAIL reset_count: got %0d want 0", count_o); end
        vecs++; if (ctl_out !== '0) begin errs++; $display("FAIL reset_ctl: got %h want 0", ctl_out); end
        vecs++; if (full_o !== 1'b0) begin errs++; $display("FAIL reset_full: got %b want 0", full_o); end
        rst = 1'b0;
        set_in(1'b0, 32'h0, 1'b0, 1'b0);
        sb.delete();
        tick();
    endtask

    task automatic test_fill();
        for (int i = 0; i < 8; i++) begin
            set_in(1'b1, 32'h60 + 32'(4 * i), 1'b0, 1'b0);
            vecs++; if (itf.ack_o !== 1'b1) begin errs++; $display("FAIL fill_ack[%0d]: got %b want 1", i, itf.ack_o); end
            vecs++; if (count_o !== 4'(i)) begin errs++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, count_o, i); end
            sb.push_back(mk(32'h60 + 32'(4 * i)));
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            set_in(1'b1, 32'h80, 1'b0, 1'b0);
            vecs++; if (itf.ack_o !== 1'b0) begin errs++; $display("FAIL full_ack[%0d]: got %b want 0", i, itf.ack_o); end
            vecs++; if (full_o !== 1'b1 || count_o !== 4'd8) begin errs++; $display("FAIL full_flag: got full=%b count=%0d want 1/8", full_o, count_o); end
            tick();
        end
        set_in(1'b1, 32'h80, 1'b1, 1'b0);
        vecs++; if (itf.ack_o !== 1'b0) begin errs++; $display("FAIL full_deq_ack: got %b want 0", itf.ack_o); end
        vecs++; if (ctl_out !== sb[0]) begin errs++; $display("FAIL full_deq_head: got %h want %h", ctl_out.pc, sb[0].pc); end
        void'(sb.pop_front());
        tick();
        set_in(1'b1, 32'h80, 1'b0, 1'b0);
        vecs++; if (itf.ack_o !== 1'b1 || full_o !== 1'b0 || count_o !== 4'd7) begin errs++; $display("FAIL refill: got ack=%b full=%b count=%0d want 1/0/7", itf.ack_o, full_o, count_o); end
        sb.push_back(mk(32'h80));
        tick();
        for (int i = 0; i < 8; i++) begin
            set_in(1'b0, 32'h0, 1'b1, 1'b0);
            vecs++; if (valid_o !== 1'b1 || ctl_out !== sb[0]) begin errs++; $display("FAIL drain[%0d]: got v=%b pc=%h want 1/%h", i, valid_o, ctl_out.pc, sb[0].pc); end
            void'(sb.pop_front());
            tick();
        end
        set_in(1'b0, 32'h0, 1'b0, 1'b0);
        vecs++; if (valid_o !== 1'b0 || count_o !== 4'd0) begin errs++; $display("FAIL drained: got v=%b count=%0d want 0/0", valid_o, count_o); end
    endtask

    task automatic test_order_wrap();
        int n_enq = 0, n_deq = 0;
        for (int c = 0; c < 60 && n_deq < 12; c++) begin
            logic ld, dq, e_ack, e_byp, e_valid;
            ld = n_enq < 12;
            dq = (c % 3) != 1;
            set_in(ld, 32'h60 + 32'(4 * n_enq), dq, 1'b0);
            e_ack = ld && sb.size() < 8;
            e_byp = BYP && ld && sb.size() == 0;
            e_valid = sb.size() != 0 || e_byp;
            vecs++; if (itf.ack_o !== e_ack || valid_o !== e_valid) begin errs++; $display("FAIL order_hs[%0d]: got ack=%b v=%b want %b/%b", c, itf.ack_o, valid_o, e_ack, e_valid); end
            if (e_valid) begin
                ctl_word eh;
                eh = sb.size() != 0 ? sb[0] : mk(32'h60 + 32'(4 * n_enq));
                vecs++; if (ctl_out !== eh || ctl_out.pc !== 32'h60 + 32'(4 * n_deq)) begin errs++; $display("FAIL order_head[%0d]: got %h want %h", c, ctl_out.pc, 32'h60 + 32'(4 * n_deq)); end
                if (dq) n_deq++;
                if (dq && sb.size() != 0) void'(sb.pop_front());
            end
            if (e_ack && !(e_byp && dq)) sb.push_back(mk(32'h60 + 32'(4 * n_enq)));
            if (e_ack) n_enq++;
            tick();
        end
        set_in(1'b0, 32'h0, 1'b0, 1'b0);
        vecs++; if (n_deq !== 12 || count_o !== 4'd0) begin errs++; $display("FAIL order_done: got deq=%0d count=%0d want 12/0", n_deq, count_o); end
    endtask

    task automatic test_simul();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 32'h90 + 32'(4 * i), 1'b0, 1'b0);
            vecs++; if (itf.ack_o !== 1'b1) begin errs++; $display("FAIL simul_fill[%0d]: got %b want 1", i, itf.ack_o); end
            sb.push_back(mk(32'h90 + 32'(4 * i)));
            tick();
        end
        set_in(1'b1, 32'h100, 1'b1, 1'b0);
        vecs++; if (itf.ack_o !== 1'b1 || ctl_out !== sb[0] || count_o !== 4'd3) begin errs++; $display("FAIL simul_both: got ack=%b pc=%h count=%0d want 1/%h/3", itf.ack_o, ctl_out.pc, count_o, sb[0].pc); end
        void'(sb.pop_front());
        sb.push_back(mk(32'h100));
        tick();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b0, 32'h0, 1'b1, 1'b0);
            if (i == 0) begin
                vecs++; if (count_o !== 4'd3) begin errs++; $display("FAIL simul_count: got %0d want 3", count_o); end
            end
            vecs++; if (valid_o !== 1'b1 || ctl_out !== sb[0]) begin errs++; $display("FAIL simul_drain[%0d]: got v=%b pc=%h want 1/%h", i, valid_o, ctl_out.pc, sb[0].pc); end
            void'(sb.pop_front());
            tick();
        end
        set_in(1'b0, 32'h0, 1'b0, 1'b0);
        vecs++; if (valid_o !== 1'b0) begin errs++; $display("FAIL simul_empty: got %b want 0", valid_o); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, 32'hA0 + 32'(4 * i), 1'b0, 1'b0);
            tick();
        end
        set_in(1'b1, 32'h1FC, 1'b1, 1'b1);
        vecs++; if (itf.ack_o !== 1'b0 || count_o !== 4'd5) begin errs++; $display("FAIL flush_cycle: got ack=%b count=%0d want 0/5", itf.ack_o, count_o); end
        tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b0);
        vecs++; if (valid_o !== 1'b0 || count_o !== 4'd0) begin errs++; $display("FAIL flush_after: got v=%b count=%0d want 0/0", valid_o, count_o); end
        set_in(1'b1, 32'h200, 1'b0, 1'b0);
        vecs++; if (itf.ack_o !== 1'b1 || valid_o !== BYP) begin errs++; $display("FAIL flush_enq: got ack=%b v=%b want 1/%b", itf.ack_o, valid_o, BYP); end
        tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b0);
        vecs++; if (valid_o !== 1'b1 || ctl_out !== mk(32'h200) || count_o !== 4'd1) begin errs++; $display("FAIL flush_head: got v=%b pc=%h count=%0d want 1/200/1", valid_o, ctl_out.pc, count_o); end
        set_in(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_bypass();
        set_in(1'b1, 32'h300, 1'b1, 1'b0);
        vecs++; if (itf.ack_o !== 1'b1 || count_o !== 4'd0) begin errs++; $display("FAIL byp_ack: got ack=%b count=%0d want 1/0", itf.ack_o, count_o); end
        vecs++; if ({valid_o, valid_o ? ctl_out.pc : 32'h0} !== {BYP, BYP ? 32'h300 : 32'h0}) begin errs++; $display("FAIL byp_same: got v=%b pc=%h want v=%b", valid_o, ctl_out.pc, BYP); end
        tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b0);
        vecs++; if ({valid_o, valid_o ? ctl_out : '0} !== {!BYP, !BYP ? mk(32'h300) : ctl_word'('0)}) begin errs++; $display("FAIL byp_next: got v=%b pc=%h want v=%b", valid_o, ctl_out.pc, !BYP); end
        vecs++; if (count_o !== (BYP ? 4'd0 : 4'd1)) begin errs++; $display("FAIL byp_count: got %0d want %0d", count_o, BYP ? 0 : 1); end
        set_in(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 2; i++) begin
            set_in(1'b1, 32'h400 + 32'(4 * i), 1'b0, 1'b0);
            tick();
        end
        rst = 1'b1;
        set_in(1'b1, 32'h408, 1'b0, 1'b0);
        vecs++; if (itf.ack_o !== 1'b0) begin errs++; $display("FAIL rstmid_ack: got %b want 0", itf.ack_o); end
        tick();
        rst = 1'b0;
        set_in(1'b0, 32'h0, 1'b0, 1'b0);
        vecs++; if (valid_o !== 1'b0 || count_o !== 4'd0 || full_o !== 1'b0 || ctl_out !== '0) begin errs++; $display("FAIL rstmid_state: got v=%b count=%0d full=%b ctl=%h want 0/0/0/0", valid_o, count_o, full_o, ctl_out); end
    endtask

    initial begin
        rst = 1'b1;
        flush_i = 1'b0;
        deq_i = 1'b0;
        itf.ld_iq = 1'b0;
        itf.control_word = '0;
        test_reset();
        test_fill();
        test_order_wrap();
        test_simul();
        test_flush();
        test_bypass();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
